bcd_seq_ctrl: RTL and testbench

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

---
 rtl/bcd_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_bcd_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_ctrl.sv
// Sequential BCD-to-binary converter: one digit per cycle, MSD first, with a
// valid/ready request and response handshake. Define BCD_SEQ_GRAY_EN to build
// the GRAY state and a registered Gray-code output.
module bcd_seq_ctrl #(
  parameter int NDIG  = 3,
  parameter int BIN_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4*NDIG-1:0] req_bcd_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [BIN_W-1:0]  rsp_bin_o,
  output logic [BIN_W-1:0]  rsp_gray_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

`ifdef BCD_SEQ_GRAY_EN
  typedef enum logic [1:0] {IDLE, CONV, GRAY, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;
`endif

  localparam logic [1:0] LastCnt = 2'(NDIG - 1);

  state_t            state_q;
  logic [4*NDIG-1:0] bcd_q;
  logic [BIN_W-1:0]  acc_q;
  logic [BIN_W-1:0]  acc_next;
  logic [1:0]        cnt_q;
  logic [1:0]        dig_idx;
  logic [3:0]        digit;
  logic              err_q;
  logic              err_next;

`ifdef BCD_SEQ_GRAY_EN
  logic [BIN_W-1:0]  gray_q;
  assign rsp_gray_o = gray_q;
`else
  assign rsp_gray_o = '0;
`endif

  // The counter runs 0..NDIG-1 while digits are consumed from the top down.
  // Modular BIN_W arithmetic gives the same result as a wide sum truncated.
  always_comb begin
    dig_idx = LastCnt - cnt_q;
    digit   = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_idx == 2'(i)) digit = bcd_q[4*i +: 4];
    end
    acc_next = acc_q * BIN_W'(10) + BIN_W'(digit);
    err_next = err_q | (digit > 4'd9);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      req_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_bin_o   <= '0;
      rsp_err_o   <= 1'b0;
`ifdef BCD_SEQ_GRAY_EN
      gray_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            bcd_q       <= req_bcd_i;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state_q     <= CONV;
          end
        end
        CONV: begin
          acc_q <= acc_next;
          err_q <= err_next;
          if (cnt_q == LastCnt) begin
            cnt_q <= '0;
`ifdef BCD_SEQ_GRAY_EN
            state_q <= GRAY;
`else
            state_q     <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_bin_o   <= err_next ? '0 : acc_next;
            rsp_err_o   <= err_next;
`endif
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
`ifdef BCD_SEQ_GRAY_EN
        GRAY: begin
          state_q     <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_bin_o   <= err_q ? '0 : acc_q;
          gray_q      <= err_q ? '0 : (acc_q ^ (acc_q >> 1));
          rsp_err_o   <= err_q;
        end
`endif
        RESP: begin
          // Payload is held until taken, then cleared so it reads 0 when idle.
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_o <= 1'b0;
            rsp_bin_o   <= '0;
            rsp_err_o   <= 1'b0;
`ifdef BCD_SEQ_GRAY_EN
            gray_q      <= '0;
`endif
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed self-checking bench for bcd_seq_ctrl (NDIG=3, BIN_W=10); expected
// latency and Gray output follow whether BCD_SEQ_GRAY_EN is defined.
module tb_bcd_seq_ctrl;

  localparam int NDIG  = 3;
  localparam int BIN_W = 10;
`ifdef BCD_SEQ_GRAY_EN
  localparam int ExpLat = NDIG + 2;
  localparam bit GrayOn = 1'b1;
`else
  localparam int ExpLat = NDIG + 1;
  localparam bit GrayOn = 1'b0;
`endif

  logic              clk_i;
  logic              rst_ni;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [4*NDIG-1:0] req_bcd_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [BIN_W-1:0]  rsp_bin_o;
  logic [BIN_W-1:0]  rsp_gray_o;
  logic              rsp_err_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;

  bcd_seq_ctrl #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_bcd_i   (req_bcd_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_bin_o   (rsp_bin_o),
    .rsp_gray_o  (rsp_gray_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running (actual running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [BIN_W-1:0] exp_gray(input logic [BIN_W-1:0] g);
    return GrayOn ? g : '0;
  endfunction

  // lat counts the negedge samples after the acceptance edge (k=1 is the cycle ending at T+1).
  task automatic wait_rsp(input int k0, output int lat);
    lat = 0;
    for (int k = k0; k <= 20; k++) begin
      @(negedge clk_i);
      if (rsp_valid_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("[TB] FAIL rsp_timeout: rsp_valid_o actual 0 for 20 cycles, required 1");
    end
  endtask

  task automatic send(input logic [11:0] bcd, output int lat);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_bcd_i   = bcd;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_bcd_i   = 12'hFFF;
    wait_rsp(1, lat);
  endtask

  task automatic release_rsp();
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_bcd_i   = '0;
    rsp_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, busy_o, rsp_valid_o, rsp_err_o, rsp_bin_o, rsp_gray_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000}) begin
      errors++;
      $display("[TB] FAIL in_reset: ready/busy/valid/err/bin/gray actual %b/%b/%b/%b/%h/%h, required 1/0/0/0/000/000",
               req_ready_o, busy_o, rsp_valid_o, rsp_err_o, rsp_bin_o, rsp_gray_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, busy_o, rsp_valid_o} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL after_reset: ready/busy/valid actual %b/%b/%b, required 1/0/0",
               req_ready_o, busy_o, rsp_valid_o);
    end
  endtask

  task automatic test_conversion(input string name, input logic [11:0] bcd,
                                 input logic [9:0] bin, input logic [9:0] gray, input logic err);
    int lat;
    send(bcd, lat);
    checks++;
    if (lat != ExpLat) begin
      errors++;
      $display("[TB] FAIL %s_latency: actual %0d, required %0d", name, lat, ExpLat);
    end
    checks++;
    if ({rsp_err_o, rsp_bin_o, rsp_gray_o} !== {err, bin, exp_gray(gray)}) begin
      errors++;
      $display("[TB] FAIL %s_payload: err/bin/gray actual %b/%h/%h, required %b/%h/%h",
               name, rsp_err_o, rsp_bin_o, rsp_gray_o, err, bin, exp_gray(gray));
    end
    release_rsp();
    checks++;
    if ({rsp_valid_o, req_ready_o, busy_o, rsp_err_o, rsp_bin_o, rsp_gray_o} !== {3'b010, 1'b0, 10'h000, 10'h000}) begin
      errors++;
      $display("[TB] FAIL %s_idle: valid/ready/busy/err/bin/gray actual %b/%b/%b/%b/%h/%h, required 0/1/0/0/000/000",
               name, rsp_valid_o, req_ready_o, busy_o, rsp_err_o, rsp_bin_o, rsp_gray_o);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(12'h042, lat);
    checks++;
    if (lat != ExpLat) begin
      errors++;
      $display("[TB] FAIL bp_latency: actual %0d, required %0d", lat, ExpLat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if ({rsp_valid_o, req_ready_o, busy_o, rsp_err_o, rsp_bin_o, rsp_gray_o} !==
          {3'b101, 1'b0, 10'h02A, exp_gray(10'h03F)}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: valid/ready/busy/err/bin/gray actual %b/%b/%b/%b/%h/%h, required 1/0/1/0/02a/%h",
                 i, rsp_valid_o, req_ready_o, busy_o, rsp_err_o, rsp_bin_o, rsp_gray_o, exp_gray(10'h03F));
      end
    end
    release_rsp();
    checks++;
    if ({rsp_valid_o, req_ready_o, busy_o, rsp_bin_o} !== {3'b010, 10'h000}) begin
      errors++;
      $display("[TB] FAIL bp_idle: valid/ready/busy/bin actual %b/%b/%b/%h, required 0/1/0/000",
               rsp_valid_o, req_ready_o, busy_o, rsp_bin_o);
    end
  endtask

  task automatic test_ignore_inputs();
    int lat;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_bcd_i   = 12'h321;
    @(posedge clk_i);
    #1;
    req_bcd_i   = 12'h999;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, busy_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL ign_conv: ready/busy actual %b/%b, required 0/1", req_ready_o, busy_o);
    end
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    wait_rsp(3, lat);
    checks++;
    if (lat != ExpLat) begin
      errors++;
      $display("[TB] FAIL ign_latency: actual %0d, required %0d", lat, ExpLat);
    end
    checks++;
    if ({rsp_err_o, rsp_bin_o, rsp_gray_o} !== {1'b0, 10'h141, exp_gray(10'h1E1)}) begin
      errors++;
      $display("[TB] FAIL ign_payload: err/bin/gray actual %b/%h/%h, required 0/141/%h",
               rsp_err_o, rsp_bin_o, rsp_gray_o, exp_gray(10'h1E1));
    end
    release_rsp();
  endtask

  task automatic test_back_to_back();
    int lat;
    send(12'h123, lat);
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_bcd_i   = 12'h005;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, busy_o, rsp_valid_o} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL b2b_gap: ready/busy/valid actual %b/%b/%b, required 1/0/0",
               req_ready_o, busy_o, rsp_valid_o);
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    wait_rsp(1, lat);
    checks++;
    if (lat != ExpLat) begin
      errors++;
      $display("[TB] FAIL b2b_latency: actual %0d, required %0d", lat, ExpLat);
    end
    checks++;
    if ({rsp_err_o, rsp_bin_o, rsp_gray_o} !== {1'b0, 10'h005, exp_gray(10'h007)}) begin
      errors++;
      $display("[TB] FAIL b2b_payload: err/bin/gray actual %b/%h/%h, required 0/005/%h",
               rsp_err_o, rsp_bin_o, rsp_gray_o, exp_gray(10'h007));
    end
    release_rsp();
  endtask

  task automatic test_mid_reset();
    int seen;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_bcd_i   = 12'h456;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    checks++;
    if ({req_ready_o, busy_o, rsp_valid_o} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL midrst_idle: ready/busy/valid actual %b/%b/%b, required 1/0/0",
               req_ready_o, busy_o, rsp_valid_o);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL midrst_no_rsp: rsp_valid_o cycles actual %0d, required 0", seen);
    end
    test_conversion("after_rst", 12'h007, 10'h007, 10'h004, 1'b0);
  endtask

  initial begin
    test_reset();
    test_conversion("conv_123", 12'h123, 10'h07B, 10'h046, 1'b0);
    test_conversion("conv_999", 12'h999, 10'h3E7, 10'h214, 1'b0);
    test_conversion("conv_000", 12'h000, 10'h000, 10'h000, 1'b0);
    test_conversion("err_mid",  12'h1A3, 10'h000, 10'h000, 1'b1);
    test_conversion("err_last", 12'h12B, 10'h000, 10'h000, 1'b1);
    test_backpressure();
    test_ignore_inputs();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
